// File: rtl/regfile_pkg.sv
// Shared register-file types and constants: widths, state and source encodings.
package regfile_pkg;

  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned REG_ZERO = 0;

  // Write sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2
  } state_e;

  // Origin of the held write
  typedef enum logic {
    SRC_WB  = 1'b0,
    SRC_SYS = 1'b1
  } src_e;

endpackage

// File: rtl/regfile_write_arbiter.sv
// Shares the Register_Group write port between pipeline writeback (primary)
// and the syscall/loader unit. Each write is held for one setup cycle with
// address/data stable, then strobed for one cycle. Writes to register 0 are
// sequenced but never strobed.
module regfile_write_arbiter
  import regfile_pkg::state_e, regfile_pkg::ST_IDLE, regfile_pkg::ST_SETUP,
         regfile_pkg::ST_STROBE, regfile_pkg::SRC_WB, regfile_pkg::SRC_SYS,
         regfile_pkg::REG_ZERO;
#(
  parameter int unsigned ADDR_W       = regfile_pkg::ADDR_W,
  parameter int unsigned DATA_W       = regfile_pkg::DATA_W,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              sys_valid,
  output logic              sys_ready,
  input  logic [ADDR_W-1:0] sys_addr,
  input  logic [DATA_W-1:0] sys_data,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_address,
  output logic [DATA_W-1:0] rf_data_in,
  output logic              busy,
  output logic              pend_valid,
  output logic [ADDR_W-1:0] pend_addr,
  output logic              grant_src
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 2);

  state_e           r_state;
  logic [CNT_W-1:0] r_starve_cnt;

  logic w_can_acc;
  logic w_force;
  logic w_wb_acc;
  logic w_sys_acc;
  logic w_addr_nz;

  // Arbitration: wb has priority unless sys has been starved long enough
  always_comb begin
    w_can_acc = (r_state == ST_IDLE) || (r_state == ST_STROBE);
    w_force   = (r_starve_cnt >= CNT_W'(STARVE_LIMIT));
    sys_ready = w_can_acc && !rst && (!wb_valid || w_force);
    wb_ready  = w_can_acc && !rst && !(w_force && sys_valid);
    w_wb_acc  = wb_valid && wb_ready;
    w_sys_acc = sys_valid && sys_ready;
    w_addr_nz = (rf_address != ADDR_W'(REG_ZERO));
  end

  // Status views of the held write for hazard/stall logic
  assign busy       = (r_state != ST_IDLE);
  assign pend_valid = busy && w_addr_nz;
  assign pend_addr  = rf_address;

  // Sequencer, held write registers and starvation counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_starve_cnt <= '0;
      rf_write     <= 1'b0;
      rf_address   <= '0;
      rf_data_in   <= '0;
      grant_src    <= SRC_WB;
    end else begin
      if (w_sys_acc || !sys_valid) begin
        r_starve_cnt <= '0;
      end else if (w_wb_acc && !w_force) begin
        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end

      case (r_state)
        ST_SETUP: begin
          r_state  <= ST_STROBE;
          rf_write <= w_addr_nz;
        end
        default: begin
          rf_write <= 1'b0;
          if (w_wb_acc) begin
            r_state    <= ST_SETUP;
            rf_address <= wb_addr;
            rf_data_in <= wb_data;
            grant_src  <= SRC_WB;
          end else if (w_sys_acc) begin
            r_state    <= ST_SETUP;
            rf_address <= sys_addr;
            rf_data_in <= sys_data;
            grant_src  <= SRC_SYS;
          end else begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vector table, a starvation
// sequence, and randomized traffic against a countdown reference model.
module tb_regfile_write_arbiter;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned NV = 19;
  localparam int unsigned NRAND = 2000;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wb_valid = 1'b0, sys_valid = 1'b0;
  logic [AW-1:0] wb_addr = '0, sys_addr = '0;
  logic [DW-1:0] wb_data = '0, sys_data = '0;
  logic          wb_ready, sys_ready, rf_write, busy, pend_valid, grant_src;
  logic [AW-1:0] rf_address, pend_addr;
  logic [DW-1:0] rf_data_in;

  int n_checks = 0;
  int n_fail   = 0;

  logic          prev_write = 1'b0;
  logic [AW-1:0] prev_addr  = '0;
  logic [DW-1:0] prev_data  = '0;

  regfile_write_arbiter dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .sys_valid(sys_valid), .sys_ready(sys_ready), .sys_addr(sys_addr), .sys_data(sys_data),
    .rf_write(rf_write), .rf_address(rf_address), .rf_data_in(rf_data_in),
    .busy(busy), .pend_valid(pend_valid), .pend_addr(pend_addr), .grant_src(grant_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          wbv;
    logic [AW-1:0] wba;
    logic [DW-1:0] wbd;
    logic          sysv;
    logic [AW-1:0] sysa;
    logic [DW-1:0] sysd;
    logic          e_wbr;
    logic          e_sysr;
    logic          e_wr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic          e_busy;
    logic          e_src;
    logic          e_pend;
  } vec_t;

  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every strobe must present the address/data already held in the prior cycle
  task automatic setup_invariant(input string tag);
    if (rf_write && !prev_write) begin
      chk({tag, " setup_addr"}, 32'(rf_address), 32'(prev_addr));
      chk({tag, " setup_data"}, rf_data_in, prev_data);
    end
    prev_write = rf_write;
    prev_addr  = rf_address;
    prev_data  = rf_data_in;
  endtask

  task automatic check_all(input string tag, input logic e_wbr, input logic e_sysr,
                           input logic e_wr, input logic [AW-1:0] e_addr,
                           input logic [DW-1:0] e_data, input logic e_busy,
                           input logic e_src, input logic e_pend);
    chk({tag, " wb_ready"},   32'(wb_ready),   32'(e_wbr));
    chk({tag, " sys_ready"},  32'(sys_ready),  32'(e_sysr));
    chk({tag, " rf_write"},   32'(rf_write),   32'(e_wr));
    chk({tag, " rf_address"}, 32'(rf_address), 32'(e_addr));
    chk({tag, " rf_data_in"}, rf_data_in,      e_data);
    chk({tag, " busy"},       32'(busy),       32'(e_busy));
    chk({tag, " grant_src"},  32'(grant_src),  32'(e_src));
    chk({tag, " pend_valid"}, 32'(pend_valid), 32'(e_pend));
    chk({tag, " pend_addr"},  32'(pend_addr),  32'(e_addr));
    setup_invariant(tag);
  endtask

  // Reference model: a write occupies the port for 2 cycles after acceptance
  int            m_left;
  int            m_starve;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic          m_src;

  initial begin
    logic          wb_pend, sys_pend;
    logic          can, frc, e_wbr, e_sysr, wacc, sacc;
    string         tag;

    // Row: rst wbv wba wbd sysv sysa sysd | wbr sysr wr addr data busy src pend
    vecs[0]  = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 5'd3, 32'h33,       1'b1, 5'd7, 32'h77, 1'b1, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h77, 1'b0, 1'b0, 1'b0, 5'd3, 32'h33,       1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h77, 1'b1, 1'b1, 1'b1, 5'd3, 32'h33,       1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b0, 5'd7, 32'h77,       1'b1, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b1, 5'd7, 32'h77,       1'b1, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b0, 5'd7, 32'h77,       1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'hAA, 1'b1, 1'b1, 1'b0, 5'd7, 32'h77,       1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b0, 5'd0, 32'hAA,       1'b1, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b0, 5'd0, 32'hAA,       1'b1, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b0, 5'd0, 32'hAA,       1'b0, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 5'd9, 32'h99,       1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b0, 5'd0, 32'hAA,       1'b0, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b0, 5'd9, 32'h99,       1'b1, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0};

    // Initial reset
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Directed vector table
    for (int i = 0; i < int'(NV); i++) begin
      @(negedge clk);
      rst = vecs[i].rst;
      wb_valid = vecs[i].wbv;   wb_addr = vecs[i].wba;   wb_data = vecs[i].wbd;
      sys_valid = vecs[i].sysv; sys_addr = vecs[i].sysa; sys_data = vecs[i].sysd;
      #1;
      tag = $sformatf("vec%0d", i);
      check_all(tag, vecs[i].e_wbr, vecs[i].e_sysr, vecs[i].e_wr, vecs[i].e_addr,
                vecs[i].e_data, vecs[i].e_busy, vecs[i].e_src, vecs[i].e_pend);
    end

    // Starvation: wb never lets go, sys must win on the 5th opportunity
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      rst       = 1'b0;
      wb_valid  = (c <= 10);
      wb_addr   = AW'(10 + (c + 1) / 2);
      wb_data   = 32'h1000 + 32'(10 + (c + 1) / 2);
      sys_valid = (c <= 8);
      sys_addr  = 5'd20;
      sys_data  = 32'h5555;
      #1;
      tag = $sformatf("starve c%0d", c);
      if (c < 8) begin
        chk({tag, " wb_ready"},  32'(wb_ready),  (c % 2 == 0) ? 32'd1 : 32'd0);
        chk({tag, " sys_ready"}, 32'(sys_ready), 32'd0);
      end else if (c == 8) begin
        chk({tag, " wb_ready"},  32'(wb_ready),  32'd0);
        chk({tag, " sys_ready"}, 32'(sys_ready), 32'd1);
      end else if (c == 9) begin
        chk({tag, " grant_src"}, 32'(grant_src), 32'd1);
        chk({tag, " rf_address"}, 32'(rf_address), 32'd20);
        chk({tag, " rf_write"},  32'(rf_write),  32'd0);
      end else if (c == 10) begin
        chk({tag, " grant_src"}, 32'(grant_src), 32'd1);
        chk({tag, " rf_write"},  32'(rf_write),  32'd1);
        chk({tag, " rf_data_in"}, rf_data_in,    32'h5555);
        chk({tag, " wb_ready"},  32'(wb_ready),  32'd1);
      end else if (c == 11) begin
        chk({tag, " grant_src"}, 32'(grant_src), 32'd0);
        chk({tag, " rf_address"}, 32'(rf_address), 32'd15);
      end
      setup_invariant(tag);
    end

    // Randomized traffic against the reference model
    @(negedge clk);
    rst = 1'b1; wb_valid = 1'b0; sys_valid = 1'b0;
    @(posedge clk);
    m_left = 0; m_starve = 0; m_addr = '0; m_data = '0; m_src = 1'b0;
    wb_pend = 1'b0; sys_pend = 1'b0;

    for (int i = 0; i < int'(NRAND); i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 99) == 0);
      if (!wb_pend && ($urandom_range(0, 3) != 0)) begin
        wb_pend = 1'b1;
        wb_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom);
        wb_data = $urandom;
      end
      if (!sys_pend && ($urandom_range(0, 2) == 0)) begin
        sys_pend = 1'b1;
        sys_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom);
        sys_data = $urandom;
      end
      wb_valid  = wb_pend;
      sys_valid = sys_pend;

      can    = (m_left != 2);
      frc    = (m_starve >= LIMIT);
      e_sysr = can && !rst && (!wb_valid || frc);
      e_wbr  = can && !rst && !(frc && sys_valid);
      #1;
      tag = $sformatf("rand%0d", i);
      check_all(tag, e_wbr, e_sysr, (m_left == 1) && (m_addr != 0), m_addr, m_data,
                m_left > 0, m_src, (m_left > 0) && (m_addr != 0));

      wacc = wb_valid && e_wbr;
      sacc = sys_valid && e_sysr;
      if (rst) begin
        m_left = 0; m_starve = 0; m_addr = '0; m_data = '0; m_src = 1'b0;
      end else begin
        if (sacc || !sys_valid) m_starve = 0;
        else if (wacc && m_starve < LIMIT) m_starve = m_starve + 1;
        if (wacc) begin
          m_left = 2; m_addr = wb_addr; m_data = wb_data; m_src = 1'b0;
        end else if (sacc) begin
          m_left = 2; m_addr = sys_addr; m_data = sys_data; m_src = 1'b1;
        end else if (m_left > 0) begin
          m_left = (m_left == 2) ? 1 : 0;
        end
      end
      if (wacc) wb_pend = 1'b0;
      if (sacc) sys_pend = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
